nios2_jtag_scan_master: RTL and testbench

// - Host-side JTAG initiator that drives TCK/TMS/TDI into a TAP (e.g. the Nios II debug-slave virtual JTAG) and samples TDO.
// - Executes one command at a time: DR scan, IR scan, TAP reset or idle clocks. Returns the captured TDO bits.
// - Sits between an on-chip test sequencer or bench and the TAP pins. All logic runs in the clk domain; TCK is a divided strobe.

---
 rtl/nios2_jtag_scan_master_if.sv | 25 ++
 rtl/nios2_jtag_scan_master.sv | 179 +++++++++++++++++
 tb/tb_nios2_jtag_scan_master.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_jtag_scan_master_if.sv
// Command/response handshake between a test sequencer and the JTAG scan master.
// The sequencer side uses the master modport, the scan master uses the slave modport.
interface nios2_jtag_scan_master_if #(
    parameter int DATA_W = 38,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/nios2_jtag_scan_master.sv
// Host-side JTAG initiator: runs one DR/IR scan, TAP reset or idle-clock command at a time
// and returns the captured TDO bits. TCK is a divided strobe generated in the clk domain.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INIT_RST | after reset: 6 TCK with TMS 1,1,1,1,1,0 to park the TAP in RTI
// IDLE     | cmd_ready=1, waiting for a command
// HDR      | TMS header (Select/Capture path), TAP-reset pattern or idle TCKs
// SHIFT    | len data TCKs, TDI from cmd_data, TDO into the capture register
// TAIL     | TMS 1,0: Exit1 -> Update -> RTI
// RSP      | rsp_valid=1 until rsp_ready
module nios2_jtag_scan_master #(
    parameter int DATA_W  = 38,
    parameter int LEN_W   = 6,
    parameter int CLK_DIV = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    nios2_jtag_scan_master_if.slave        host,
    output logic                           tck,
    output logic                           tms,
    output logic                           tdi,
    input  logic                           tdo
);
    typedef enum logic [2:0] {INIT_RST, IDLE, HDR, SHIFT, TAIL, RSP} state_t;

    localparam int               DIV_W     = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DATA_W);
    localparam logic [5:0]       PAT_RESET = 6'b011111;
    localparam logic [1:0]       OP_DR     = 2'b00;
    localparam logic [1:0]       OP_IR     = 2'b01;
    localparam logic [1:0]       OP_RST    = 2'b10;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div_cnt;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [1:0]        op_q;
    logic [5:0]        pat;
    logic [DATA_W-1:0] sh_data;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] rsp_data_q;

    logic              accept, running, div_tc, phase_done;
    logic [1:0]        op_c;
    logic [LEN_W-1:0]  len_cl, len_c;
    logic              enter, ld_tms, cmd_ready_c, rsp_valid_c;
    logic [5:0]        ld_pat;
    logic [LEN_W-1:0]  ld_n;

    assign len_cl     = (host.cmd_len > LEN_MAX) ? LEN_MAX : host.cmd_len;
    assign accept     = (state == IDLE) && host.cmd_valid;
    assign running    = state inside {INIT_RST, HDR, SHIFT, TAIL};
    assign div_tc     = (div_cnt == '0);
    assign phase_done = running && div_tc && tck && (bit_cnt == '0);
    // On the accept clk the command is not yet registered, so load from the bus.
    assign op_c       = (state == IDLE) ? host.cmd_op : op_q;
    assign len_c      = (state == IDLE) ? len_cl : len_q;

    always_ff @(posedge clk) begin
        if (reset) state <= INIT_RST;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT_RST: if (phase_done) state_nx = IDLE;
            IDLE: begin
                if (host.cmd_valid)
                    state_nx = (host.cmd_op == 2'b11 && len_cl == '0) ? RSP : HDR;
            end
            HDR: begin
                if (phase_done) begin
                    if (op_q == OP_DR || op_q == OP_IR) state_nx = (len_q == '0) ? TAIL : SHIFT;
                    else                                state_nx = RSP;
                end
            end
            SHIFT:   if (phase_done) state_nx = TAIL;
            TAIL:    if (phase_done) state_nx = RSP;
            RSP:     if (host.rsp_ready) state_nx = IDLE;
            default: state_nx = INIT_RST;
        endcase
    end

    // Pattern bits are consumed LSB first; a zero-length scan turns the Capture->Shift 0 into a 1.
    always_comb begin
        cmd_ready_c = (state == IDLE);
        rsp_valid_c = (state == RSP);
        enter       = (state_nx != state) && (state_nx inside {HDR, SHIFT, TAIL});
        ld_pat      = '0;
        ld_n        = len_c;
        case (state_nx)
            HDR: begin
                case (op_c)
                    OP_DR:   begin ld_pat = (len_c == '0) ? 6'b000101 : 6'b000001; ld_n = LEN_W'(3); end
                    OP_IR:   begin ld_pat = (len_c == '0) ? 6'b001011 : 6'b000011; ld_n = LEN_W'(4); end
                    OP_RST:  begin ld_pat = PAT_RESET; ld_n = LEN_W'(6); end
                    default: ld_pat = '0;
                endcase
            end
            TAIL: begin
                ld_pat = 6'b000001;
                ld_n   = LEN_W'(2);
            end
            default: ld_pat = '0;
        endcase
        ld_tms = (state_nx == SHIFT) ? (len_c == LEN_W'(1)) : ld_pat[0];
    end

    assign host.cmd_ready = cmd_ready_c;
    assign host.rsp_valid = rsp_valid_c;
    assign host.rsp_data  = rsp_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= DIV_LOAD;
            bit_cnt    <= LEN_W'(5);
            pat        <= PAT_RESET >> 1;
            tck        <= 1'b0;
            tms        <= 1'b1;
            tdi        <= 1'b0;
            op_q       <= OP_DR;
            len_q      <= '0;
            sh_data    <= '0;
            cap        <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                op_q       <= host.cmd_op;
                len_q      <= len_cl;
                sh_data    <= host.cmd_data;
                cap        <= '0;
                rsp_data_q <= '0;
            end
            if (enter) begin
                div_cnt <= DIV_LOAD;
                tck     <= 1'b0;
                bit_cnt <= ld_n - LEN_W'(1);
                tms     <= ld_tms;
                pat     <= ld_pat >> 1;
                if (state_nx == SHIFT) begin
                    tdi     <= sh_data[0];
                    sh_data <= sh_data >> 1;
                end else begin
                    tdi <= 1'b0;
                end
                // First captured bit sits at DATA_W-len; right-align it to bit 0.
                if (state == SHIFT) rsp_data_q <= cap >> (LEN_MAX - len_q);
            end else if (running) begin
                if (!div_tc) begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end else begin
                    div_cnt <= DIV_LOAD;
                    if (!tck) begin
                        tck <= 1'b1;
                        if (state == SHIFT) cap <= {tdo, cap[DATA_W-1:1]};
                    end else begin
                        tck <= 1'b0;
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - LEN_W'(1);
                            if (state == SHIFT) begin
                                tms     <= (bit_cnt == LEN_W'(1));
                                tdi     <= sh_data[0];
                                sh_data <= sh_data >> 1;
                            end else begin
                                tms <= pat[0];
                                pat <= pat >> 1;
                            end
                        end else begin
                            tdi <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nios2_jtag_scan_master.sv
// Directed bench for nios2_jtag_scan_master with a behavioural 16-state TAP model
// (8-bit DR, 10-bit IR) that logs TMS per TCK and checks TDI is 0 outside Shift.
module tb_nios2_jtag_scan_master;
    localparam int DATA_W  = 38;
    localparam int LEN_W   = 6;
    localparam int CLK_DIV = 2;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tck, tms, tdi, tdo;
    logic tdo_tie = 1'b0;
    logic tap_tdo = 1'b0;

    int checks = 0;
    int failures = 0;

    tap_t        tap_st = TLR;
    logic [7:0]  dr_reg = 8'h3C;
    logic [7:0]  dr_sh = 8'h00;
    logic [9:0]  ir_reg = 10'h3FF;
    logic [9:0]  ir_sh = 10'h000;
    logic [63:0] tms_log = '0;
    int          tck_cnt = 0;
    time         r0 = 0;
    time         r1 = 0;
    logic        tdi_bad = 1'b0;

    nios2_jtag_scan_master_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    nios2_jtag_scan_master #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .host  (bus),
        .tck   (tck),
        .tms   (tms),
        .tdi   (tdi),
        .tdo   (tdo)
    );

    always #5 clk = ~clk;

    assign tdo = tdo_tie ? 1'b1 : tap_tdo;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PA_DR;
            PA_DR:   return m ? EX2_DR : PA_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PA_IR;
            PA_IR:   return m ? EX2_IR : PA_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        if (tck_cnt < 64) tms_log[tck_cnt] = tms;
        if (tck_cnt == 0) r0 = $time;
        else if (tck_cnt == 1) r1 = $time;
        tck_cnt++;
        if (!(tap_st inside {SH_DR, SH_IR}) && tdi !== 1'b0) tdi_bad = 1'b1;
        case (tap_st)
            CAP_DR:  dr_sh = dr_reg;
            SH_DR:   dr_sh = {tdi, dr_sh[7:1]};
            UPD_DR:  dr_reg = dr_sh;
            CAP_IR:  ir_sh = 10'h001;
            SH_IR:   ir_sh = {tdi, ir_sh[9:1]};
            UPD_IR:  ir_reg = ir_sh;
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms);
    end

    always @(negedge tck) begin
        if (tap_st == SH_DR)      tap_tdo = dr_sh[0];
        else if (tap_st == SH_IR) tap_tdo = ir_sh[0];
        else                      tap_tdo = 1'b0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        tck_cnt = 0;
        tms_log = '0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data);
        @(negedge clk);
        check("ready_before_cmd", bus.cmd_ready, 1'b1);
        clear_log();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, seen, 1'b1);
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, bus.rsp_valid, 1'b0);
        check({tag, "_ready_back"}, bus.cmd_ready, 1'b1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        logic [DATA_W-1:0] snap;
        bit stable;
        bit hit;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 64'h0);
        check("rst_tck", tck, 1'b0);
        check("rst_tms", tms, 1'b1);
        check("rst_tdi", tdi, 1'b0);
        clear_log();
        reset = 1'b0;

        wait_ready("init_ready", 200);
        check("init_tck_count", tck_cnt, 6);
        check("init_tms", tms_log, 64'h1F);
        check("init_tck_period", r1 - r0, 40);
        check("init_tap_rti", tap_st == RTI, 1'b1);

        // DR scan, 8 bits of 0xA5 into a DR preset to 0x3C
        issue(2'b00, 6'd8, 38'hA5);
        check("dr8_ready_drop", bus.cmd_ready, 1'b0);
        wait_rsp("dr8_rsp_timeout", 300);
        check("dr8_tck_count", tck_cnt, 13);
        check("dr8_tms", tms_log, 64'h0C01);
        check("dr8_rsp_data", bus.rsp_data, 64'h3C);
        check("dr8_tdi_into_dr", dr_reg, 8'hA5);
        check("dr8_tck_low", tck, 1'b0);
        check("dr8_tap_rti", tap_st == RTI, 1'b1);
        finish_rsp("dr8");

        // IR scan, 10 bits of 0x002; IR capture pattern 0x001
        issue(2'b01, 6'd10, 38'h002);
        wait_rsp("ir10_rsp_timeout", 300);
        check("ir10_tck_count", tck_cnt, 16);
        check("ir10_tms", tms_log, 64'h6003);
        check("ir10_rsp_data", bus.rsp_data, 64'h001);
        check("ir10_tdi_into_ir", ir_reg, 10'h002);
        finish_rsp("ir10");

        // Clamped DR scan (45 -> 38), tdo tied high, then 20 clk of backpressure
        tdo_tie = 1'b1;
        issue(2'b00, 6'd45, {DATA_W{1'b1}});
        wait_rsp("dr45_rsp_timeout", 400);
        check("dr45_tck_count", tck_cnt, 43);
        check("dr45_tms", tms_log, 64'h0000_0300_0000_0001);
        snap = bus.rsp_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== snap || bus.cmd_ready !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1'b1);
        check("dr45_rsp_data", bus.rsp_data, 64'h3F_FFFF_FFFF);
        finish_rsp("dr45");
        tdo_tie = 1'b0;

        // Zero-length DR scan: Capture straight to Exit1
        issue(2'b00, 6'd0, 38'h15);
        wait_rsp("dr0_rsp_timeout", 200);
        check("dr0_tck_count", tck_cnt, 5);
        check("dr0_tms", tms_log, 64'h0D);
        check("dr0_rsp_data", bus.rsp_data, 64'h0);
        finish_rsp("dr0");

        // Idle clocks, len 3
        issue(2'b11, 6'd3, 38'h3);
        wait_rsp("idle3_rsp_timeout", 200);
        check("idle3_tck_count", tck_cnt, 3);
        check("idle3_tms", tms_log, 64'h0);
        check("idle3_rsp_data", bus.rsp_data, 64'h0);
        finish_rsp("idle3");

        // TAP reset op
        issue(2'b10, 6'd0, 38'h0);
        wait_rsp("trst_rsp_timeout", 200);
        check("trst_tck_count", tck_cnt, 6);
        check("trst_tms", tms_log, 64'h1F);
        check("trst_rsp_data", bus.rsp_data, 64'h0);
        check("trst_tap_rti", tap_st == RTI, 1'b1);
        finish_rsp("trst");

        // Idle clocks, len 0: no TCK, response on the next clk
        issue(2'b11, 6'd0, 38'h0);
        check("idle0_rsp_next_clk", bus.rsp_valid, 1'b1);
        check("idle0_tck_count", tck_cnt, 0);
        check("idle0_rsp_data", bus.rsp_data, 64'h0);
        finish_rsp("idle0");

        // Reset in the middle of a 30-bit DR shift
        issue(2'b00, 6'd30, 38'h2AAA_AAAA);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (tck_cnt >= 10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reach_shift", hit, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tck", tck, 1'b0);
        check("midrst_tms", tms, 1'b1);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_cmd_ready", bus.cmd_ready, 1'b0);
        @(negedge clk);
        clear_log();
        reset = 1'b0;
        wait_ready("reinit_ready", 200);
        check("reinit_tck_count", tck_cnt, 6);
        check("reinit_tms", tms_log, 64'h1F);
        check("reinit_tap_rti", tap_st == RTI, 1'b1);

        check("tdi_zero_outside_shift", tdi_bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
